// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Purpose:
//   Sits between a byte-oriented serial link and a combinational ALU. Three
//   received bytes form one command: operand A, operand B and an opcode. The
//   operands and opcode are held in registers that feed the ALU directly. One
//   cycle after the opcode arrives, the ALU result is captured and sent back
//   over the link, followed by a flag byte {err, 0..., zero, carry}.
//   A stalled command (idle too long between bytes) is abandoned silently.
//   Bytes that arrive while a command is executing or transmitting are
//   dropped and recorded in a sticky overrun flag.
//
// Ports:
//   i_clock      - single rising-edge clock
//   i_reset      - synchronous active-high reset (wins over every other input)
//   i_rx_data    - received byte, valid while i_rx_valid is high
//   i_rx_valid   - one-cycle receive strobe
//   o_a, o_b     - registered ALU operands
//   o_op         - registered ALU opcode
//   i_alu_res    - combinational ALU result
//   i_alu_carry  - combinational ALU carry
//   o_tx_data    - byte offered to the transmitter
//   o_tx_start   - one-cycle request to transmit o_tx_data
//   i_tx_done    - one-cycle strobe: transmitter finished a byte
//   o_busy       - high whenever a command is in progress (state != WAIT_A)
//   o_overrun    - sticky: a received byte was dropped
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int OP_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [OP_WIDTH-1:0]   o_op,
    input  logic [DATA_WIDTH-1:0] i_alu_res,
    input  logic                  i_alu_carry,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_overrun
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Accepted opcodes, 6 bits each, packed so they can be walked by index:
    // ADD, SUB, AND, OR, XOR, NOR, SRA, SRL.
    localparam int NUM_OPS = 8;
    localparam logic [NUM_OPS*6-1:0] VALID_OPS = {
        6'b000010,  // SRL
        6'b000011,  // SRA
        6'b100111,  // NOR
        6'b100110,  // XOR
        6'b100101,  // OR
        6'b100100,  // AND
        6'b100010,  // SUB
        6'b100000   // ADD
    };

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND_RES,
        WAIT_RES,
        SEND_FLG,
        WAIT_FLG
    } state_t;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   a_reg;
    logic [DATA_WIDTH-1:0]   b_reg;
    logic [OP_WIDTH-1:0]     op_reg;
    logic [DATA_WIDTH-1:0]   tx_data_reg;
    logic                    tx_start_reg;
    logic                    busy_reg;
    logic                    overrun_reg;
    logic [CNT_W-1:0]        timeout_cnt_reg;

    // Captured execution results
    logic [DATA_WIDTH-1:0]   res_reg;
    logic                    carry_reg;
    logic                    zero_reg;
    logic                    err_reg;

    // -------------------------------------------------------------------------
    // Opcode decode: one comparator per legal opcode, error if none match
    // -------------------------------------------------------------------------
    logic [NUM_OPS-1:0] op_match;

    generate
        for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op_decode
            assign op_match[gi] = (op_reg == OP_WIDTH'(VALID_OPS[gi*6 +: 6]));
        end
    endgenerate

    // Values captured at the end of EXEC. An illegal opcode suppresses the
    // whole result so the host never sees a half-meaningful answer.
    logic                  err_next;
    logic [DATA_WIDTH-1:0] res_next;
    logic                  carry_next;
    logic                  zero_next;

    always_comb begin
        err_next   = ~|op_match;
        res_next   = err_next ? '0 : i_alu_res;
        carry_next = err_next ? 1'b0 : i_alu_carry;
        zero_next  = err_next ? 1'b0 : (i_alu_res == '0);
    end

    // Flag byte: err in the MSB, zero in bit 1, carry in bit 0, rest zero.
    logic [DATA_WIDTH-1:0] flag_byte;

    always_comb begin
        flag_byte               = '0;
        flag_byte[DATA_WIDTH-1] = err_reg;
        flag_byte[1]            = zero_reg;
        flag_byte[0]            = carry_reg;
    end

    // Receive bytes are only meaningful while collecting a command.
    logic rx_accept_state;

    always_comb begin
        rx_accept_state = (state_reg == WAIT_A) ||
                          (state_reg == WAIT_B) ||
                          (state_reg == WAIT_OP);
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg       <= WAIT_A;
            a_reg           <= '0;
            b_reg           <= '0;
            op_reg          <= '0;
            tx_data_reg     <= '0;
            tx_start_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
            timeout_cnt_reg <= '0;
            res_reg         <= '0;
            carry_reg       <= 1'b0;
            zero_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            // o_tx_start is a single-cycle pulse unless a state re-asserts it.
            tx_start_reg <= 1'b0;

            if (i_rx_valid && !rx_accept_state) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                WAIT_A: begin
                    timeout_cnt_reg <= '0;
                    if (i_rx_valid) begin
                        a_reg     <= i_rx_data;
                        busy_reg  <= 1'b1;
                        state_reg <= WAIT_B;
                    end
                end

                // An rx byte in the timeout cycle is still accepted, so the
                // receive check comes before the timeout check.
                WAIT_B: begin
                    if (i_rx_valid) begin
                        b_reg           <= i_rx_data;
                        timeout_cnt_reg <= '0;
                        state_reg       <= WAIT_OP;
                    end else if (timeout_cnt_reg == CNT_LAST) begin
                        timeout_cnt_reg <= '0;
                        busy_reg        <= 1'b0;
                        state_reg       <= WAIT_A;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
                    end
                end

                WAIT_OP: begin
                    if (i_rx_valid) begin
                        op_reg          <= i_rx_data[OP_WIDTH-1:0];
                        timeout_cnt_reg <= '0;
                        state_reg       <= EXEC;
                    end else if (timeout_cnt_reg == CNT_LAST) begin
                        timeout_cnt_reg <= '0;
                        busy_reg        <= 1'b0;
                        state_reg       <= WAIT_A;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
                    end
                end

                // The ALU has had one full cycle on the new opcode. The result
                // byte and its start pulse are loaded here so they appear
                // during SEND_RES, two cycles after the opcode strobe.
                EXEC: begin
                    res_reg      <= res_next;
                    carry_reg    <= carry_next;
                    zero_reg     <= zero_next;
                    err_reg      <= err_next;
                    tx_data_reg  <= res_next;
                    tx_start_reg <= 1'b1;
                    state_reg    <= SEND_RES;
                end

                SEND_RES: begin
                    state_reg <= WAIT_RES;
                end

                WAIT_RES: begin
                    if (i_tx_done) begin
                        tx_data_reg  <= flag_byte;
                        tx_start_reg <= 1'b1;
                        state_reg    <= SEND_FLG;
                    end
                end

                SEND_FLG: begin
                    state_reg <= WAIT_FLG;
                end

                WAIT_FLG: begin
                    if (i_tx_done) begin
                        timeout_cnt_reg <= '0;
                        busy_reg        <= 1'b0;
                        state_reg       <= WAIT_A;
                    end
                end

                default: begin
                    timeout_cnt_reg <= '0;
                    busy_reg        <= 1'b0;
                    state_reg       <= WAIT_A;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_a        = a_reg;
    assign o_b        = b_reg;
    assign o_op       = op_reg;
    assign o_tx_data  = tx_data_reg;
    assign o_tx_start = tx_start_reg;
    assign o_busy     = busy_reg;
    assign o_overrun  = overrun_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Purpose:
//   Directed self-checking bench for alu_cmd_sequencer with TIMEOUT_CYCLES=16.
//   A small behavioural ALU answers the operand/opcode registers. Inputs are
//   driven 1 time unit after each rising edge and outputs are checked at the
//   same point, so every check sees the state registered by the last edge.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    localparam int DW = 8;
    localparam int OW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
    logic [DW-1:0] alu_res;
    logic          alu_carry;
    logic [DW-1:0] tx_data;
    logic          tx_start;
    logic          tx_done = 1'b0;
    logic          busy;
    logic          overrun;

    int errors = 0;
    int checks = 0;
    int tx_cnt = 0;
    int exp_pulses = 0;

    alu_cmd_sequencer #(
        .DATA_WIDTH    (DW),
        .OP_WIDTH      (OW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_a        (a),
        .o_b        (b),
        .o_op       (op),
        .i_alu_res  (alu_res),
        .i_alu_carry(alu_carry),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start),
        .i_tx_done  (tx_done),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Behavioural ALU. Unknown opcodes give a nonzero result and carry so
    // the bench can see that the sequencer suppresses them.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            6'h20: {alu_carry, alu_res} = {1'b0, a} + {1'b0, b};
            6'h22: {alu_carry, alu_res} = {1'b0, a} - {1'b0, b};
            6'h24: alu_res = a & b;
            6'h25: alu_res = a | b;
            6'h26: alu_res = a ^ b;
            6'h27: alu_res = ~(a | b);
            default: begin
                alu_res   = a ^ b;
                alu_carry = 1'b1;
            end
        endcase
    end

    // Count transmit requests.
    always @(posedge clk) begin
        if (tx_start) tx_cnt <= tx_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [DW-1:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // Called right after the opcode byte was sent. Walks the response and
    // checks latency, both bytes and the pulse count. With inject set, an
    // extra rx byte is pushed during WAIT_RES.
    task automatic expect_tx(input string tag, input logic [OW-1:0] exp_op,
                             input logic [DW-1:0] exp_res, input logic [DW-1:0] exp_flg,
                             input bit inject);
        $display("cmd %s: op=0x%0h expect res=0x%0h flg=0x%0h", tag, exp_op, exp_res, exp_flg);
        check({tag, " op"}, 32'(op), 32'(exp_op));
        check({tag, " start_exec"}, 32'(tx_start), 32'd0);
        tick();
        check({tag, " start_lat2"}, 32'(tx_start), 32'd1);
        check({tag, " res"}, 32'(tx_data), 32'(exp_res));
        tick();
        check({tag, " start_waitres"}, 32'(tx_start), 32'd0);
        check({tag, " res_hold"}, 32'(tx_data), 32'(exp_res));
        if (inject) begin
            send_byte(8'hAA);
            check({tag, " overrun"}, 32'(overrun), 32'd1);
            check({tag, " res_after_drop"}, 32'(tx_data), 32'(exp_res));
            check({tag, " start_after_drop"}, 32'(tx_start), 32'd0);
        end
        pulse_done();
        check({tag, " start_flg"}, 32'(tx_start), 32'd1);
        check({tag, " flg"}, 32'(tx_data), 32'(exp_flg));
        tick();
        check({tag, " start_waitflg"}, 32'(tx_start), 32'd0);
        check({tag, " busy_waitflg"}, 32'(busy), 32'd1);
        pulse_done();
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        exp_pulses += 2;
        check({tag, " pulses"}, 32'(tx_cnt), 32'(exp_pulses));
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        rst = 1'b0;
        check("rst a", 32'(a), 32'd0);
        check("rst b", 32'(b), 32'd0);
        check("rst op", 32'(op), 32'd0);
        check("rst tx_data", 32'(tx_data), 32'd0);
        check("rst tx_start", 32'(tx_start), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);

        // ---------------- ADD 5+3 ----------------
        send_byte(8'h05);
        check("add a", 32'(a), 32'h05);
        check("add busy", 32'(busy), 32'd1);
        send_byte(8'h03);
        check("add b", 32'(b), 32'h03);
        send_byte(8'h20);
        expect_tx("add", 6'h20, 8'h08, 8'h00, 1'b0);

        // ---------------- ADD FF+01: zero and carry ----------------
        send_byte(8'hFF);
        send_byte(8'h01);
        send_byte(8'h20);
        expect_tx("add_zc", 6'h20, 8'h00, 8'h03, 1'b0);

        // ---------------- invalid opcode ----------------
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h3F);
        expect_tx("invalid", 6'h3F, 8'h00, 8'h80, 1'b0);

        // ---------------- SUB 5-7: borrow ----------------
        send_byte(8'h05);
        send_byte(8'h07);
        send_byte(8'h22);
        expect_tx("sub", 6'h22, 8'hFE, 8'h01, 1'b0);

        // ---------------- XOR equal operands: zero only ----------------
        send_byte(8'h5A);
        send_byte(8'h5A);
        send_byte(8'h26);
        expect_tx("xor", 6'h26, 8'h00, 8'h02, 1'b0);

        // ---------------- tx_done while idle is ignored ----------------
        pulse_done();
        check("idle_done busy", 32'(busy), 32'd0);
        check("idle_done start", 32'(tx_start), 32'd0);

        // ---------------- timeout in WAIT_B ----------------
        send_byte(8'h05);
        for (int i = 0; i < 15; i++) tick();
        check("to busy_15", 32'(busy), 32'd1);
        tick();
        check("to busy_16", 32'(busy), 32'd0);
        check("to pulses", 32'(tx_cnt), 32'(exp_pulses));
        check("to a_kept", 32'(a), 32'h05);
        check("to b_kept", 32'(b), 32'h5A);
        check("to op_kept", 32'(op), 32'h26);
        send_byte(8'h07);
        check("to new_a", 32'(a), 32'h07);

        // ---------------- rx on the timeout cycle wins ----------------
        for (int i = 0; i < 15; i++) tick();
        send_byte(8'h01);
        check("to_race b", 32'(b), 32'h01);
        check("to_race busy", 32'(busy), 32'd1);
        send_byte(8'h20);
        expect_tx("to_race", 6'h20, 8'h08, 8'h00, 1'b0);

        // ---------------- overrun during WAIT_RES ----------------
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        expect_tx("overrun", 6'h20, 8'h08, 8'h00, 1'b1);
        check("overrun a_kept", 32'(a), 32'h05);
        send_byte(8'h0C);
        send_byte(8'h0A);
        send_byte(8'h24);
        expect_tx("and", 6'h24, 8'h08, 8'h00, 1'b0);
        check("overrun sticky", 32'(overrun), 32'd1);

        // ---------------- reset during WAIT_RES ----------------
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        tick();
        check("rst_mid start", 32'(tx_start), 32'd1);
        exp_pulses += 1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid a", 32'(a), 32'd0);
        check("rst_mid b", 32'(b), 32'd0);
        check("rst_mid op", 32'(op), 32'd0);
        check("rst_mid tx_data", 32'(tx_data), 32'd0);
        check("rst_mid tx_start", 32'(tx_start), 32'd0);
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid overrun", 32'(overrun), 32'd0);
        pulse_done();
        tick();
        tick();
        check("rst_mid late_done busy", 32'(busy), 32'd0);
        check("rst_mid pulses", 32'(tx_cnt), 32'(exp_pulses));

        // ---------------- normal command after reset ----------------
        send_byte(8'h0F);
        send_byte(8'hF0);
        send_byte(8'h27);
        expect_tx("nor", 6'h27, 8'h00, 8'h02, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of operands, result and serial-link bytes.
REQ-002 Parameter OP_WIDTH, default 6: width of the ALU opcode.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000: maximum number of idle cycles allowed between command bytes.
REQ-004 Port i_clock, input, 1: the single clock; all logic is rising-edge.
REQ-005 Port i_reset, input, 1: synchronous, active-high reset.
REQ-006 Port i_rx_data, input, DATA_WIDTH: received byte from the serial receiver.
REQ-007 Port i_rx_valid, input, 1: one-cycle pulse; i_rx_data is valid on that cycle.
REQ-008 Port o_a and port o_b, output, DATA_WIDTH each: registered operands driven to the ALU.
REQ-009 Port o_op, output, OP_WIDTH: registered opcode driven to the ALU.
REQ-010 Port i_alu_res, input, DATA_WIDTH: combinational ALU result.
REQ-011 Port i_alu_carry, input, 1: ALU carry.
REQ-012 Port o_tx_data, output, DATA_WIDTH: byte to transmit.
REQ-013 Port o_tx_start, output, 1: one-cycle pulse requesting transmission of o_tx_data.
REQ-014 Port i_tx_done, input, 1: one-cycle pulse when the transmitter finishes a byte.
REQ-015 Port o_busy, output, 1: high whenever the state is not WAIT_A.
REQ-016 Port o_overrun, output, 1: sticky flag meaning an rx byte was dropped.

Function
REQ-017 The FSM SHALL have states WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG and WAIT_FLG.
REQ-018 On i_rx_valid in WAIT_A the block SHALL latch o_a <= i_rx_data and go to WAIT_B.
REQ-019 On i_rx_valid in WAIT_B the block SHALL latch o_b and go to WAIT_OP.
REQ-020 On i_rx_valid in WAIT_OP the block SHALL latch o_op from i_rx_data[OP_WIDTH-1:0] and go to EXEC.
REQ-021 EXEC SHALL last exactly one cycle (ALU settle) and SHALL capture res <= i_alu_res, carry <= i_alu_carry, zero <= (i_alu_res == 0), and err <= (opcode is not in the valid set).
REQ-022 The valid opcode set SHALL be 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL.
REQ-023 When err is set, the captured res SHALL be forced to 0, and carry and zero SHALL be forced to 0.
REQ-024 SEND_RES SHALL drive o_tx_data = res, pulse o_tx_start for one cycle, and go to WAIT_RES.
REQ-025 WAIT_RES SHALL hold o_tx_data until i_tx_done, then go to SEND_FLG.
REQ-026 SEND_FLG SHALL drive o_tx_data = {err, zeros, zero, carry}, with err in the MSB, carry in bit 0 and zero in bit 1, then pulse o_tx_start and go to WAIT_FLG.
REQ-027 WAIT_FLG SHALL return to WAIT_A on i_tx_done.
REQ-028 Latency: the first o_tx_start SHALL occur exactly 2 cycles after the cycle of the opcode i_rx_valid.
REQ-029 o_tx_start SHALL never be asserted while a transmission is pending, i.e. in WAIT_RES or WAIT_FLG.
REQ-030 The timeout counter SHALL clear on every accepted rx byte and on entry to WAIT_A.
REQ-031 The timeout counter SHALL increment in WAIT_B and WAIT_OP only.
REQ-032 When the timeout counter reaches TIMEOUT_CYCLES-1, the FSM SHALL return to WAIT_A without transmitting; o_a, o_b and o_op SHALL keep their values.
REQ-033 If i_rx_valid coincides with the timeout cycle, the byte SHALL be accepted and the timeout SHALL NOT fire.
REQ-034 An i_rx_valid in EXEC, SEND_*, or WAIT_* SHALL be dropped and SHALL set o_overrun, which stays set until reset.
REQ-035 An i_tx_done outside WAIT_RES or WAIT_FLG SHALL be ignored.
REQ-036 o_a, o_b and o_op SHALL be stable from latch until the next accepted write of the same field.

Reset
REQ-037 While i_reset is high at a clock edge: state <= WAIT_A; o_a, o_b, o_op, o_tx_data <= 0; o_tx_start, o_busy, o_overrun <= 0; timeout counter, res and flags <= 0.
REQ-038 A reset asserted mid-operation (any state, including WAIT_RES) SHALL abort without a further o_tx_start; a late i_tx_done after reset SHALL be ignored.
REQ-039 i_reset SHALL have priority over i_rx_valid and i_tx_done on the same edge.

Verification (TIMEOUT_CYCLES = 16 for sim)
REQ-040 Scenario: rx 0x05, 0x03, 0x20 (ADD), then tx_done after each byte -> o_a=0x05, o_b=0x03, o_op=0x20; tx bytes 0x08 then 0x00; o_tx_start exactly 2 cycles after the opcode rx.
REQ-041 Scenario: rx 0xFF, 0x01, 0x20 -> tx bytes 0x00 then 0x03 (zero=1, carry=1).
REQ-042 Scenario: rx 0x05, 0x03, 0x3F (invalid) -> tx bytes 0x00 then 0x80.
REQ-043 Scenario: rx 0x05 then 16 idle cycles -> FSM back in WAIT_A with o_busy=0 and no o_tx_start; a subsequent rx 0x07 latches o_a=0x07.
REQ-044 Scenario: extra rx byte during WAIT_RES -> o_overrun=1; result unchanged; the next command executes normally.
REQ-045 Scenario: reset pulse during WAIT_RES -> all outputs 0 next cycle; no o_tx_start follows; the next i_tx_done is ignored.
